// File: rtl/cdb_arbiter_if.sv
// Common-data-bus arbitration bundle: requester results in, grants and CDB write ports out.
// The master side is the producers/ROB control; the slave side is the arbiter.
interface cdb_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int IDX_W   = 4
);
    logic [NUM_REQ-1:0]        req_valid_flat;
    logic [NUM_REQ*IDX_W-1:0]  req_rob_idx_flat;
    logic [NUM_REQ*DATA_W-1:0] req_value_flat;
    logic [NUM_REQ-1:0]        req_ready_flat;
    logic                      flush;
    logic                      cdb_stall;
    logic [1:0]                cdb_valid_flat;
    logic [2*IDX_W-1:0]        cdb_rob_idx_flat;
    logic [2*DATA_W-1:0]       cdb_value_flat;
    logic [$clog2(NUM_REQ)-1:0] rr_ptr;

    modport master (
        output req_valid_flat, req_rob_idx_flat, req_value_flat, flush, cdb_stall,
        input  req_ready_flat, cdb_valid_flat, cdb_rob_idx_flat, cdb_value_flat, rr_ptr
    );

    modport slave (
        input  req_valid_flat, req_rob_idx_flat, req_value_flat, flush, cdb_stall,
        output req_ready_flat, cdb_valid_flat, cdb_rob_idx_flat, cdb_value_flat, rr_ptr
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter granting up to two of four result producers per cycle onto the
// two registered CDB write ports; honours flush and ROB back-pressure.
module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int IDX_W   = 4
) (
    input logic          clk,
    input logic          rst_n,
    cdb_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_REQ);

    logic              req_vld [NUM_REQ];
    logic [IDX_W-1:0]  req_idx [NUM_REQ];
    logic [DATA_W-1:0] req_val [NUM_REQ];

    // Requester i lives at the most-significant end of each flat vector.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_vld[i] = bus.req_valid_flat[NUM_REQ-1-i];
        assign req_idx[i] = bus.req_rob_idx_flat[IDX_W*(NUM_REQ-1-i) +: IDX_W];
        assign req_val[i] = bus.req_value_flat[DATA_W*(NUM_REQ-1-i) +: DATA_W];
    end

    logic             grant_en;
    logic             gnt_a_vld, gnt_b_vld;
    logic [PTR_W-1:0] gnt_a, gnt_b, cand;
    logic [PTR_W-1:0] rr_ptr_p1;
    logic [1:0]       vld_p1;
    logic [IDX_W-1:0] idx_a_p1, idx_b_p1;
    logic [DATA_W-1:0] val_a_p1, val_b_p1;
    logic [NUM_REQ-1:0] ready_flat;

    assign grant_en = rst_n & ~bus.flush & ~bus.cdb_stall;

    // Stage p0: scan from rr_ptr, first hit takes port 0, second hit takes port 1.
    always_comb begin
        gnt_a_vld = 1'b0;
        gnt_b_vld = 1'b0;
        gnt_a     = '0;
        gnt_b     = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = rr_ptr_p1 + PTR_W'(k);
            if (grant_en && req_vld[cand]) begin
                if (!gnt_a_vld) begin
                    gnt_a_vld = 1'b1;
                    gnt_a     = cand;
                end else if (!gnt_b_vld) begin
                    gnt_b_vld = 1'b1;
                    gnt_b     = cand;
                end
            end
        end
    end

    always_comb begin
        ready_flat = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ready_flat[NUM_REQ-1-i] = (gnt_a_vld && (gnt_a == PTR_W'(i))) ||
                                      (gnt_b_vld && (gnt_b == PTR_W'(i)));
        end
    end

    // Stage p1: CDB registers; idx/value hold when their port carries no grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= '0;
            idx_a_p1  <= '0;
            idx_b_p1  <= '0;
            val_a_p1  <= '0;
            val_b_p1  <= '0;
            rr_ptr_p1 <= '0;
        end else begin
            vld_p1 <= {gnt_a_vld, gnt_b_vld};
            if (gnt_a_vld) begin
                idx_a_p1 <= req_idx[gnt_a];
                val_a_p1 <= req_val[gnt_a];
            end
            if (gnt_b_vld) begin
                idx_b_p1 <= req_idx[gnt_b];
                val_b_p1 <= req_val[gnt_b];
            end
            if (gnt_b_vld)
                rr_ptr_p1 <= gnt_b + PTR_W'(1);
            else if (gnt_a_vld)
                rr_ptr_p1 <= gnt_a + PTR_W'(1);
        end
    end

    assign bus.req_ready_flat   = ready_flat;
    assign bus.cdb_valid_flat   = vld_p1;
    assign bus.cdb_rob_idx_flat = {idx_a_p1, idx_b_p1};
    assign bus.cdb_value_flat   = {val_a_p1, val_b_p1};
    assign bus.rr_ptr           = rr_ptr_p1;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: round-robin order, single grant, wrap, stall, flush
// and mid-operation reset, each against hand-computed CDB contents.
module tb_cdb_arbiter;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    cdb_arbiter_if #(.NUM_REQ(4), .DATA_W(16), .IDX_W(4)) bus ();

    cdb_arbiter #(.NUM_REQ(4), .DATA_W(16), .IDX_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_req(input int i, input logic v, input logic [3:0] idx, input logic [15:0] val);
        bus.req_valid_flat[3-i]             = v;
        bus.req_rob_idx_flat[4*(3-i) +: 4]  = idx;
        bus.req_value_flat[16*(3-i) +: 16]  = val;
    endtask

    task automatic all_valid();
        set_req(0, 1'b1, 4'd1, 16'h0011);
        set_req(1, 1'b1, 4'd2, 16'h0022);
        set_req(2, 1'b1, 4'd3, 16'h0033);
        set_req(3, 1'b1, 4'd4, 16'h0044);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.cdb_stall = 1'b0;
        all_valid();
        #2;
        n_cmp++; if (bus.cdb_valid_flat !== 2'b00) begin n_err++; $display("FAIL reset_valid got %b want 00", bus.cdb_valid_flat); end
        n_cmp++; if (bus.cdb_rob_idx_flat !== 8'h00) begin n_err++; $display("FAIL reset_idx got %h want 00", bus.cdb_rob_idx_flat); end
        n_cmp++; if (bus.cdb_value_flat !== 32'h0) begin n_err++; $display("FAIL reset_value got %h want 0", bus.cdb_value_flat); end
        n_cmp++; if (bus.rr_ptr !== 2'd0) begin n_err++; $display("FAIL reset_ptr got %0d want 0", bus.rr_ptr); end
        n_cmp++; if (bus.req_ready_flat !== 4'b0000) begin n_err++; $display("FAIL reset_ready got %b want 0000", bus.req_ready_flat); end
    endtask

    task automatic test_round_robin();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (bus.req_ready_flat !== 4'b1100) begin n_err++; $display("FAIL rr_c0_ready got %b want 1100", bus.req_ready_flat); end
        tick();
        n_cmp++; if (bus.cdb_valid_flat !== 2'b11) begin n_err++; $display("FAIL rr_c1_valid got %b want 11", bus.cdb_valid_flat); end
        n_cmp++; if (bus.cdb_rob_idx_flat !== 8'h12) begin n_err++; $display("FAIL rr_c1_idx got %h want 12", bus.cdb_rob_idx_flat); end
        n_cmp++; if (bus.cdb_value_flat !== 32'h0011_0022) begin n_err++; $display("FAIL rr_c1_value got %h want 00110022", bus.cdb_value_flat); end
        n_cmp++; if (bus.rr_ptr !== 2'd2) begin n_err++; $display("FAIL rr_c1_ptr got %0d want 2", bus.rr_ptr); end
        n_cmp++; if (bus.req_ready_flat !== 4'b0011) begin n_err++; $display("FAIL rr_c1_ready got %b want 0011", bus.req_ready_flat); end
        tick();
        n_cmp++; if (bus.cdb_rob_idx_flat !== 8'h34) begin n_err++; $display("FAIL rr_c2_idx got %h want 34", bus.cdb_rob_idx_flat); end
        n_cmp++; if (bus.cdb_value_flat !== 32'h0033_0044) begin n_err++; $display("FAIL rr_c2_value got %h want 00330044", bus.cdb_value_flat); end
        n_cmp++; if (bus.rr_ptr !== 2'd0) begin n_err++; $display("FAIL rr_c2_ptr got %0d want 0", bus.rr_ptr); end
    endtask

    task automatic test_single();
        set_req(0, 1'b0, 4'd0, 16'h0);
        set_req(1, 1'b0, 4'd0, 16'h0);
        set_req(2, 1'b1, 4'd7, 16'hBEEF);
        set_req(3, 1'b0, 4'd0, 16'h0);
        #1;
        n_cmp++; if (bus.req_ready_flat !== 4'b0010) begin n_err++; $display("FAIL single_ready got %b want 0010", bus.req_ready_flat); end
        tick();
        n_cmp++; if (bus.cdb_valid_flat !== 2'b10) begin n_err++; $display("FAIL single_valid got %b want 10", bus.cdb_valid_flat); end
        n_cmp++; if (bus.cdb_rob_idx_flat !== 8'h74) begin n_err++; $display("FAIL single_idx got %h want 74", bus.cdb_rob_idx_flat); end
        n_cmp++; if (bus.cdb_value_flat !== 32'hBEEF_0044) begin n_err++; $display("FAIL single_value got %h want beef0044", bus.cdb_value_flat); end
        n_cmp++; if (bus.rr_ptr !== 2'd3) begin n_err++; $display("FAIL single_ptr got %0d want 3", bus.rr_ptr); end
    endtask

    task automatic test_wrap();
        set_req(0, 1'b1, 4'hA, 16'h0A0A);
        set_req(2, 1'b0, 4'd0, 16'h0);
        set_req(3, 1'b1, 4'h9, 16'h3333);
        #1;
        n_cmp++; if (bus.req_ready_flat !== 4'b1001) begin n_err++; $display("FAIL wrap_ready got %b want 1001", bus.req_ready_flat); end
        tick();
        n_cmp++; if (bus.cdb_rob_idx_flat !== 8'h9A) begin n_err++; $display("FAIL wrap_idx got %h want 9a", bus.cdb_rob_idx_flat); end
        n_cmp++; if (bus.cdb_value_flat !== 32'h3333_0A0A) begin n_err++; $display("FAIL wrap_value got %h want 33330a0a", bus.cdb_value_flat); end
        n_cmp++; if (bus.rr_ptr !== 2'd1) begin n_err++; $display("FAIL wrap_ptr got %0d want 1", bus.rr_ptr); end
    endtask

    task automatic test_stall();
        all_valid();
        bus.cdb_stall = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_cmp++; if (bus.req_ready_flat !== 4'b0000) begin n_err++; $display("FAIL stall_ready[%0d] got %b want 0000", c, bus.req_ready_flat); end
            tick();
            n_cmp++; if (bus.cdb_valid_flat !== 2'b00) begin n_err++; $display("FAIL stall_valid[%0d] got %b want 00", c, bus.cdb_valid_flat); end
            n_cmp++; if (bus.rr_ptr !== 2'd1) begin n_err++; $display("FAIL stall_ptr[%0d] got %0d want 1", c, bus.rr_ptr); end
        end
        bus.cdb_stall = 1'b0;
        #1;
        n_cmp++; if (bus.req_ready_flat !== 4'b0110) begin n_err++; $display("FAIL stall_resume_ready got %b want 0110", bus.req_ready_flat); end
        tick();
        n_cmp++; if (bus.cdb_rob_idx_flat !== 8'h23) begin n_err++; $display("FAIL stall_resume_idx got %h want 23", bus.cdb_rob_idx_flat); end
        n_cmp++; if (bus.rr_ptr !== 2'd3) begin n_err++; $display("FAIL stall_resume_ptr got %0d want 3", bus.rr_ptr); end
    endtask

    task automatic test_flush();
        #1;
        n_cmp++; if (bus.req_ready_flat !== 4'b1001) begin n_err++; $display("FAIL flush_pre_ready got %b want 1001", bus.req_ready_flat); end
        tick();
        bus.flush = 1'b1;
        #1;
        n_cmp++; if (bus.req_ready_flat !== 4'b0000) begin n_err++; $display("FAIL flush_ready got %b want 0000", bus.req_ready_flat); end
        n_cmp++; if (bus.cdb_valid_flat !== 2'b11) begin n_err++; $display("FAIL flush_prior_valid got %b want 11", bus.cdb_valid_flat); end
        n_cmp++; if (bus.cdb_rob_idx_flat !== 8'h41) begin n_err++; $display("FAIL flush_prior_idx got %h want 41", bus.cdb_rob_idx_flat); end
        n_cmp++; if (bus.rr_ptr !== 2'd1) begin n_err++; $display("FAIL flush_prior_ptr got %0d want 1", bus.rr_ptr); end
        tick();
        n_cmp++; if (bus.cdb_valid_flat !== 2'b00) begin n_err++; $display("FAIL flush_post_valid got %b want 00", bus.cdb_valid_flat); end
        n_cmp++; if (bus.rr_ptr !== 2'd1) begin n_err++; $display("FAIL flush_post_ptr got %0d want 1", bus.rr_ptr); end
        bus.flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        #1;
        n_cmp++; if (bus.req_ready_flat !== 4'b0110) begin n_err++; $display("FAIL rmid_pre_ready got %b want 0110", bus.req_ready_flat); end
        tick();
        n_cmp++; if (bus.cdb_valid_flat !== 2'b11) begin n_err++; $display("FAIL rmid_pre_valid got %b want 11", bus.cdb_valid_flat); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.cdb_valid_flat !== 2'b00) begin n_err++; $display("FAIL rmid_valid got %b want 00", bus.cdb_valid_flat); end
        n_cmp++; if (bus.cdb_rob_idx_flat !== 8'h00) begin n_err++; $display("FAIL rmid_idx got %h want 00", bus.cdb_rob_idx_flat); end
        n_cmp++; if (bus.cdb_value_flat !== 32'h0) begin n_err++; $display("FAIL rmid_value got %h want 0", bus.cdb_value_flat); end
        n_cmp++; if (bus.rr_ptr !== 2'd0) begin n_err++; $display("FAIL rmid_ptr got %0d want 0", bus.rr_ptr); end
        n_cmp++; if (bus.req_ready_flat !== 4'b0000) begin n_err++; $display("FAIL rmid_ready got %b want 0000", bus.req_ready_flat); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (bus.req_ready_flat !== 4'b1100) begin n_err++; $display("FAIL rmid_post_ready got %b want 1100", bus.req_ready_flat); end
        tick();
        n_cmp++; if (bus.cdb_rob_idx_flat !== 8'h12) begin n_err++; $display("FAIL rmid_post_idx got %h want 12", bus.cdb_rob_idx_flat); end
        n_cmp++; if (bus.rr_ptr !== 2'd2) begin n_err++; $display("FAIL rmid_post_ptr got %0d want 2", bus.rr_ptr); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_round_robin();
        test_single();
        test_wrap();
        test_stall();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
